sipo_frame_rx: RTL and testbench

Serial frame receiver: the receive end of the one-bit-per-clock serial link our shift-register chains drive. It detects a start bit on `din` and shifts in `WIDTH` data bits. It checks the stop bit and, optionally, a parity bit, then presents the word on a parallel valid/ready port. It sits between a serial shift-register output and the parallel datapath, and contains a one-entry output buffer with overrun and frame-error reporting.

---
 rtl/sipo_rx_pkg.sv | 14 +
 rtl/sipo_rx_shift.sv | 36 +++
 rtl/sipo_frame_rx.sv | 128 ++++++++++++
 tb/tb_sipo_frame_rx.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/sipo_rx_pkg.sv
// Shared types and line-level constants for the serial frame receiver.
package sipo_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  localparam logic RX_START_BIT = 1'b1;
  localparam logic RX_STOP_BIT  = 1'b0;

endpackage

// File: rtl/sipo_rx_shift.sv
// Data shift register for the frame receiver, with selectable bit ordering.
// With SIPO_RX_PARITY_EN defined it also keeps a running XOR of the shifted bits.
module sipo_rx_shift #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             bit_in,
`ifdef SIPO_RX_PARITY_EN
  input  logic             clear,
  output logic             parity,
`endif
  output logic [WIDTH-1:0] data
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data <= '0;
    end else if (shift_en) begin
      // After WIDTH shifts the first bit sits at the far end chosen by MSB_FIRST
      if (MSB_FIRST) data <= {data[WIDTH-2:0], bit_in};
      else           data <= {bit_in, data[WIDTH-1:1]};
    end
  end

`ifdef SIPO_RX_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         parity <= 1'b0;
    else if (clear)    parity <= 1'b0;
    else if (shift_en) parity <= parity ^ bit_in;
  end
`endif

endmodule

// File: rtl/sipo_frame_rx.sv
// Serial frame receiver: start bit, WIDTH data bits, optional even parity, stop bit,
// delivered through a one-entry valid/ready buffer. Parity is enabled by SIPO_RX_PARITY_EN.
//
// state  | meaning
// IDLE   | waiting for a start bit (din = 1)
// DATA   | shifting in the WIDTH data bits
// PARITY | sampling the parity bit (SIPO_RX_PARITY_EN only)
// STOP   | sampling the stop bit, committing or discarding the word
module sipo_frame_rx
  import sipo_rx_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  rx_state_t        state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shift_data;
  logic             frame_good;
  logic             commit;
  logic             handshake;

`ifdef SIPO_RX_PARITY_EN
  logic parity_run;
  logic parity_bad;
`endif

  sipo_rx_shift #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk      (clk),
    .reset    (reset),
    .shift_en (state == DATA),
    .bit_in   (din),
`ifdef SIPO_RX_PARITY_EN
    .clear    (state == IDLE),
    .parity   (parity_run),
`endif
    .data     (shift_data)
  );

  always_comb begin
    frame_good = (din == RX_STOP_BIT);
`ifdef SIPO_RX_PARITY_EN
    frame_good = frame_good && !parity_bad;
`endif
    commit    = (state == STOP) && frame_good;
    handshake = dout_valid && dout_ready;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      busy       <= 1'b0;
      frame_err  <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
`ifdef SIPO_RX_PARITY_EN
      parity_bad <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          cnt  <= '0;
          busy <= (din == RX_START_BIT);
          if (din == RX_START_BIT) state <= DATA;
        end
        DATA: begin
          busy <= 1'b1;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST_BIT) begin
`ifdef SIPO_RX_PARITY_EN
            state <= PARITY;
`else
            state <= STOP;
`endif
          end
        end
`ifdef SIPO_RX_PARITY_EN
        PARITY: begin
          busy       <= 1'b1;
          parity_bad <= parity_run ^ din;
          state      <= STOP;
        end
`endif
        STOP: begin
          // busy stays high for the cycle after the stop edge
          busy  <= 1'b1;
          state <= IDLE;
          if (!frame_good) frame_err <= 1'b1;
        end
        default: state <= IDLE;
      endcase

      // A handshake on the commit edge frees the slot, so the new word wins
      if (commit) begin
        if (!dout_valid || handshake) begin
          dout       <= shift_data;
          dout_valid <= 1'b1;
          if (handshake) overrun <= 1'b0;
        end else begin
          overrun <= 1'b1;
        end
      end else if (handshake) begin
        dout_valid <= 1'b0;
        overrun    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Bench for sipo_frame_rx (WIDTH=8, MSB_FIRST=1): directed scenarios then random frames,
// checked every cycle against a frame-level model. Honours SIPO_RX_PARITY_EN.
module tb_sipo_frame_rx;

  localparam int W = 8;
`ifdef SIPO_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         din = 1'b0;
  logic         dout_ready = 1'b0;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic         busy;
  logic         frame_err;
  logic         overrun;

  sipo_frame_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [W-1:0] exp_dout  = '0;
  logic         exp_valid = 1'b0;
  logic         exp_ovr   = 1'b0;
  logic         exp_ferr  = 1'b0;
  logic         exp_busy  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("dout_valid", 32'(dout_valid), 32'(exp_valid));
    chk("dout",       32'(dout),       32'(exp_dout));
    chk("overrun",    32'(overrun),    32'(exp_ovr));
    chk("frame_err",  32'(frame_err),  32'(exp_ferr));
    chk("busy",       32'(busy),       32'(exp_busy));
  endtask

  task automatic model_reset();
    exp_dout = '0; exp_valid = 1'b0; exp_ovr = 1'b0; exp_ferr = 1'b0; exp_busy = 1'b0;
  endtask

  // One line bit: update the model for the coming edge, clock it, then compare.
  task automatic step(input logic d, input logic r, input logic in_frame,
                      input logic is_stop, input logic good, input logic [W-1:0] word);
    logic hs;
    din = d;
    dout_ready = r;
    hs = exp_valid && r;
    exp_ferr = is_stop && !good;
    exp_busy = in_frame;
    if (is_stop && good) begin
      if (!exp_valid || hs) begin
        exp_dout = word;
        exp_valid = 1'b1;
        if (hs) exp_ovr = 1'b0;
      end else begin
        exp_ovr = 1'b1;
      end
    end else if (hs) begin
      exp_valid = 1'b0;
      exp_ovr = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
    check_all();
  endtask

  function automatic logic pick_ready(input int mode, input logic last);
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      3:       return last;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // mode: 0 ready low, 1 ready high, 2 random, 3 high only on the stop bit
  task automatic send_frame(input logic [W-1:0] data, input logic stop_bit,
                            input logic par_flip, input int mode);
    int   len;
    logic good;
    logic b;
    len  = W + PB + 2;
    good = (stop_bit == 1'b0) && !(PB == 1 && par_flip);
    for (int k = 0; k < len; k++) begin
      if (k == 0)            b = 1'b1;
      else if (k <= W)       b = data[W-k];
      else if (k == len - 1) b = stop_bit;
      else                   b = (^data) ^ par_flip;
      step(b, pick_ready(mode, k == len - 1), 1'b1, k == len - 1, good, data);
    end
  endtask

  task automatic idle(input int n, input int mode);
    for (int i = 0; i < n; i++) step(1'b0, pick_ready(mode, 1'b0), 1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    // Reset state
    @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;
    idle(2, 0);

    // Single frame with ready held high: one-cycle presentation
    send_frame(8'hA5, 1'b0, 1'b0, 1);
    chk("a5_dout", 32'(dout), 32'h0000_00A5);
    chk("a5_valid", 32'(dout_valid), 32'd1);
    idle(1, 1);
    chk("a5_one_cycle", 32'(dout_valid), 32'd0);
    idle(2, 1);

    // Bad stop bit, then a normal frame
    send_frame(8'hA5, 1'b1, 1'b0, 1);
    chk("badstop_ferr", 32'(frame_err), 32'd1);
    chk("badstop_valid", 32'(dout_valid), 32'd0);
    idle(1, 1);
    send_frame(8'h5A, 1'b0, 1'b0, 1);
    chk("after_bad_dout", 32'(dout), 32'h0000_005A);
    idle(2, 1);

    // Overrun: two back-to-back frames with no consumer
    send_frame(8'h3C, 1'b0, 1'b0, 0);
    send_frame(8'hC3, 1'b0, 1'b0, 0);
    chk("ovr_dout", 32'(dout), 32'h0000_003C);
    chk("ovr_flag", 32'(overrun), 32'd1);
    idle(1, 1);
    chk("ovr_cleared", 32'(overrun), 32'd0);
    chk("ovr_valid_cleared", 32'(dout_valid), 32'd0);
    idle(1, 0);

    // Handshake on the stop edge of the second frame
    send_frame(8'h3C, 1'b0, 1'b0, 0);
    send_frame(8'hC3, 1'b0, 1'b0, 3);
    chk("simul_dout", 32'(dout), 32'h0000_00C3);
    chk("simul_valid", 32'(dout_valid), 32'd1);
    chk("simul_ovr", 32'(overrun), 32'd0);
    idle(2, 1);

    // Reset mid-frame after four data bits
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    din = 1'b0;
    reset = 1'b1;
    #2;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_all();
    send_frame(8'h81, 1'b0, 1'b0, 1);
    chk("post_reset_dout", 32'(dout), 32'h0000_0081);
    idle(3, 1);

`ifdef SIPO_RX_PARITY_EN
    send_frame(8'hA5, 1'b0, 1'b0, 1);
    chk("par_ok_valid", 32'(dout_valid), 32'd1);
    idle(1, 1);
    send_frame(8'hA5, 1'b0, 1'b1, 1);
    chk("par_bad_ferr", 32'(frame_err), 32'd1);
    chk("par_bad_valid", 32'(dout_valid), 32'd0);
    idle(1, 1);
`endif

    // Random frames, random gaps, random consumer
    for (int f = 0; f < 150; f++) begin
      send_frame(W'($urandom), 1'($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 7) == 0), 2);
      idle($urandom_range(0, 2), 2);
    end
    // Consumer always ready, back-to-back frames
    for (int f = 0; f < 20; f++) begin
      send_frame(W'($urandom), 1'($urandom_range(0, 9) == 0), 1'b0, 1);
    end
    idle(3, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
